// File: rtl/spw_pkg.sv
// Constants shared by the SpaceWire receive path: buffer sizing, the
// flow-control credit step and ceiling, and the control-character codes.
package spw_pkg;

  localparam int SPW_DEPTH       = 64;
  localparam int SPW_CREDIT_STEP = 8;
  localparam int SPW_MAX_CREDIT  = 56;

  localparam logic [8:0] SPW_EOP = 9'h100;
  localparam logic [8:0] SPW_EEP = 9'h101;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/spw_fifo_mem.sv
// Dual-port character storage with a registered read port; only the read
// register is reset, the array keeps its contents.
module spw_fifo_mem #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             pclk,
  input  logic             resetn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rx_fifo_credit.sv
// Receive FIFO with SpaceWire FCT credit accounting: tracks credit held by the
// remote end and requests an FCT only when the buffer can absorb it.
module rx_fifo_credit
  import spw_pkg::*;
#(
  parameter  int DEPTH       = SPW_DEPTH,
  parameter  int CREDIT_STEP = SPW_CREDIT_STEP,
  parameter  int MAX_CREDIT  = SPW_MAX_CREDIT,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          resetn,
  input  logic          link_run,
  input  logic          rx_buffer_write,
  input  logic [8:0]    rx_data_flag,
  input  logic          rd_en,
  output logic [8:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [5:0]    credit_count,
  output logic          fct_req,
  input  logic          fct_ack,
  output logic          credit_error
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic [5:0]    credit_q, credit_d;
  logic          fct_req_q, fct_req_d;
  logic          err_q, err_d;

  logic wr_accept, rd_accept, ack_accept, credit_dec;
  int   need, room;

  always_comb begin
    wr_accept  = link_run & rx_buffer_write & ~full_q;
    rd_accept  = rd_en & ~empty_q;
    ack_accept = fct_ack & fct_req_q;
    credit_dec = wr_accept & (credit_q != 6'd0);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d  = count_q + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, rd_accept};
    credit_d = credit_q - {5'd0, credit_dec} + (ack_accept ? 6'(CREDIT_STEP) : 6'd0);
    err_d    = err_q | (link_run & rx_buffer_write & ((credit_q == 6'd0) | full_q));

    // Link down discards everything, including any read in the same cycle.
    if (!link_run) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      credit_d = '0;
      err_d    = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));

    // Judged on post-update values so a granted FCT never outruns free space.
    need      = int'(credit_d) + CREDIT_STEP;
    room      = min_int(MAX_CREDIT, DEPTH - int'(count_d));
    fct_req_d = link_run & (need <= room);
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      credit_q  <= '0;
      fct_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      credit_q  <= credit_d;
      fct_req_q <= fct_req_d;
      err_q     <= err_d;
    end
  end

  spw_fifo_mem #(.DEPTH(DEPTH), .WIDTH(9)) u_mem (
    .pclk   (pclk),
    .resetn (resetn),
    .we     (wr_accept),
    .waddr  (wr_ptr_q),
    .wdata  (rx_data_flag),
    .re     (rd_accept),
    .raddr  (rd_ptr_q),
    .rdata  (rd_data)
  );

  assign empty        = empty_q;
  assign full         = full_q;
  assign count        = count_q;
  assign credit_count = credit_q;
  assign fct_req      = fct_req_q;
  assign credit_error = err_q;

endmodule
